// File: rtl/sram_bridge_if.sv
// sram_bridge_if: core data-bus and external SRAM signals of the bridge.
// bus_error exists only when SRAM_BRIDGE_BOUNDS_EN is defined.
interface sram_bridge_if #(parameter int ADDR_W = 20);
    logic [31:0]       bus_address;
    logic [3:0]        bus_byteenable;
    logic              bus_read;
    logic              bus_write;
    logic [31:0]       bus_wrdata;
    logic [31:0]       bus_rddata;
    logic              bus_stall;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_data_o;
    logic [31:0]       sram_data_i;
    logic              sram_data_oe;
    logic [3:0]        sram_be_n;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
`ifdef SRAM_BRIDGE_BOUNDS_EN
    logic              bus_error;
`endif

    modport slave (
        input  bus_address, bus_byteenable, bus_read, bus_write, bus_wrdata, sram_data_i,
        output bus_rddata, bus_stall, sram_addr, sram_data_o, sram_data_oe, sram_be_n,
               sram_ce_n, sram_oe_n, sram_we_n
`ifdef SRAM_BRIDGE_BOUNDS_EN
        , output bus_error
`endif
    );

    modport master (
        output bus_address, bus_byteenable, bus_read, bus_write, bus_wrdata, sram_data_i,
        input  bus_rddata, bus_stall, sram_addr, sram_data_o, sram_data_oe, sram_be_n,
               sram_ce_n, sram_oe_n, sram_we_n
`ifdef SRAM_BRIDGE_BOUNDS_EN
        , input bus_error
`endif
    );
endinterface

// File: rtl/sram_bridge.sv
// sram_bridge: single-outstanding data-bus to async 32-bit SRAM bridge with wait states.
// Optional SRAM_BRIDGE_BOUNDS_EN rejects addresses beyond the SRAM and flags bus_error.
module sram_bridge #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input logic          clk,
    input logic          rst,
    sram_bridge_if.slave b
);
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       data_q;
    logic [31:0]       rddata_q;
    logic              err_q;
    logic              req, oob, rd, wr;
    logic              unused_bits;

    assign req = b.bus_read || b.bus_write;
`ifdef SRAM_BRIDGE_BOUNDS_EN
    assign oob         = |b.bus_address[31:ADDR_W+2];
    assign b.bus_error = (state_q == DONE) && err_q;
`else
    assign oob = 1'b0;
`endif
    assign unused_bits = ^{b.bus_address[1:0], b.bus_address[31:ADDR_W+2], err_q};

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (req) state_d = oob ? DONE : (b.bus_read ? RD : WR_SETUP);
                if (req && b.bus_read) wcnt_d = 4'(RD_WAIT);
            end
            RD: begin
                state_d = (wcnt_q == 4'd0) ? DONE : RD;
                wcnt_d  = (wcnt_q == 4'd0) ? wcnt_q : wcnt_q - 4'd1;
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                wcnt_d  = 4'(WR_WAIT - 1);
            end
            WR_PULSE: begin
                state_d = (wcnt_q == 4'd0) ? WR_HOLD : WR_PULSE;
                wcnt_d  = (wcnt_q == 4'd0) ? wcnt_q : wcnt_q - 4'd1;
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            data_q   <= '0;
            rddata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            // Latched copies keep the SRAM cycle immune to requester changes while stalled.
            if (state_q == IDLE && req) begin
                addr_q <= b.bus_address[ADDR_W+1:2];
                be_q   <= b.bus_byteenable;
                err_q  <= oob;
                if (!b.bus_read) data_q <= b.bus_wrdata;
                if (oob && b.bus_read) rddata_q <= '0;
            end
            if (state_q == RD && wcnt_q == 4'd0) rddata_q <= b.sram_data_i;
        end
    end

    // Strobes decode straight from state so reset releases them asynchronously.
    assign rd             = state_q == RD;
    assign wr             = state_q == WR_SETUP || state_q == WR_PULSE || state_q == WR_HOLD;
    assign b.sram_ce_n    = !(rd || wr);
    assign b.sram_oe_n    = !rd;
    assign b.sram_we_n    = state_q != WR_PULSE;
    assign b.sram_be_n    = rd ? 4'b0000 : (wr ? ~be_q : 4'b1111);
    assign b.sram_data_oe = wr;
    assign b.sram_addr    = addr_q;
    assign b.sram_data_o  = data_q;
    assign b.bus_rddata   = rddata_q;
    assign b.bus_stall    = (state_q == IDLE && req) || (state_q != IDLE && state_q != DONE);
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: scoreboard bench for sram_bridge against a behavioural async SRAM.
module tb_sram_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] mem [0:63];
    logic [31:0] exp_q [$];
    bit   mem_en = 1'b0;
    int   stall_cnt, oe_cnt, we_cnt, ce_cnt, overlap, err_cnt;
    logic [3:0]  last_be_n;
    logic [19:0] last_addr;

    sram_bridge_if #(.ADDR_W(20)) bif ();

    sram_bridge #(.ADDR_W(20), .RD_WAIT(2), .WR_WAIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .b   (bif)
    );

    always #5 clk = ~clk;

    assign bif.sram_data_i = mem[bif.sram_addr[5:0]];

    // The SRAM commits on the rising edge of we_n, with byte lanes from be_n.
    always @(posedge bif.sram_we_n)
        if (mem_en && !rst && !bif.sram_ce_n)
            for (int i = 0; i < 4; i++)
                if (!bif.sram_be_n[i]) mem[bif.sram_addr[5:0]][8*i +: 8] = bif.sram_data_o[8*i +: 8];

    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd, input bit hold,
                              input bit scramble);
        logic [31:0] exp;
        bit done = 1'b0;
        @(posedge clk); #1;
        bif.bus_read = rd; bif.bus_write = wr; bif.bus_address = addr;
        bif.bus_byteenable = be; bif.bus_wrdata = wd;
        stall_cnt = 0; oe_cnt = 0; we_cnt = 0; ce_cnt = 0; overlap = 0; err_cnt = 0;
        last_be_n = 4'hf; last_addr = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!bif.sram_oe_n) oe_cnt++;
            if (!bif.sram_we_n) begin we_cnt++; last_be_n = bif.sram_be_n; end
            if (!bif.sram_ce_n) begin ce_cnt++; last_addr = bif.sram_addr; end
            if (!bif.sram_oe_n && !bif.sram_we_n) overlap++;
`ifdef SRAM_BRIDGE_BOUNDS_EN
            if (bif.bus_error) err_cnt++;
`endif
            if (bif.bus_stall) stall_cnt++;
            else done = 1'b1;
            if (scramble && c == 1) begin
                bif.bus_address = 32'h0000_003C; bif.bus_wrdata = 32'hBAD0_BAD0;
            end
        end
        tests++;
        if (!done) begin
            fails++; $display("FAIL timeout: stall still high after 40 cycles, addr %h", addr);
        end
        if (rd) begin
            exp = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
            tests++;
            if (bif.bus_rddata !== exp) begin
                fails++; $display("FAIL rddata addr %h: got %h expected %h", addr, bif.bus_rddata, exp);
            end
        end
        tests++;
        if (overlap !== 0) begin
            fails++; $display("FAIL oe_we_overlap: got %0d cycles expected 0", overlap);
        end
        if (!hold) begin
            @(posedge clk); #1;
            bif.bus_read = 1'b0; bif.bus_write = 1'b0;
        end
    endtask

    task automatic test_reset();
        bif.bus_read = 0; bif.bus_write = 0; bif.bus_address = '0;
        bif.bus_byteenable = '0; bif.bus_wrdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        tests++;
        if ({bif.bus_stall, bif.sram_ce_n, bif.sram_oe_n, bif.sram_we_n, bif.sram_data_oe} !== 5'b01110) begin
            fails++; $display("FAIL reset_strobes: got stall/ce/oe/we/doe %b expected 01110",
                {bif.bus_stall, bif.sram_ce_n, bif.sram_oe_n, bif.sram_we_n, bif.sram_data_oe});
        end
        tests++;
        if ({bif.sram_be_n, bif.sram_addr, bif.sram_data_o, bif.bus_rddata} !== {4'hf, 20'h0, 32'h0, 32'h0}) begin
            fails++; $display("FAIL reset_regs: got be_n %h addr %h data_o %h rddata %h expected f/0/0/0",
                bif.sram_be_n, bif.sram_addr, bif.sram_data_o, bif.bus_rddata);
        end
    endtask

    task automatic test_read();
        mem[4] = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        run_access(1, 0, 32'h0000_0010, 4'hf, 32'h0, 0, 0);
        tests++;
        if (stall_cnt !== 4) begin fails++; $display("FAIL read_stall: got %0d expected 4", stall_cnt); end
        tests++;
        if (oe_cnt !== 3) begin fails++; $display("FAIL read_oe: got %0d expected 3", oe_cnt); end
        tests++;
        if (last_addr !== 20'd4) begin fails++; $display("FAIL read_addr: got %h expected 4", last_addr); end
        tests++;
        if (we_cnt !== 0) begin fails++; $display("FAIL read_we: got %0d expected 0", we_cnt); end
    endtask

    task automatic test_byte_write();
        mem[2] = 32'h1122_3344;
        mem[3] = 32'h5566_7788;
        run_access(0, 1, 32'h0000_0008, 4'b0010, 32'h0000_AB00, 0, 0);
        tests++;
        if (last_be_n !== 4'b1101) begin fails++; $display("FAIL write_be_n: got %b expected 1101", last_be_n); end
        tests++;
        if (we_cnt !== 2) begin fails++; $display("FAIL write_we: got %0d expected 2", we_cnt); end
        tests++;
        if (stall_cnt !== 5) begin fails++; $display("FAIL write_stall: got %0d expected 5", stall_cnt); end
        tests++;
        if (mem[2] !== 32'h1122_AB44) begin fails++; $display("FAIL write_mem: got %h expected 1122ab44", mem[2]); end
        tests++;
        if (mem[3] !== 32'h5566_7788) begin fails++; $display("FAIL write_neighbour: got %h expected 55667788", mem[3]); end
        tests++;
        if (bif.bus_rddata !== 32'hDEADBEEF) begin fails++; $display("FAIL write_rddata_hold: got %h expected deadbeef", bif.bus_rddata); end
    endtask

    task automatic test_read_write_both();
        mem[1] = 32'hCAFE_F00D;
        exp_q.push_back(32'hCAFE_F00D);
        run_access(1, 1, 32'h0000_0004, 4'hf, 32'h0BAD_0BAD, 0, 0);
        tests++;
        if (we_cnt !== 0) begin fails++; $display("FAIL both_we: got %0d expected 0", we_cnt); end
        tests++;
        if (mem[1] !== 32'hCAFE_F00D) begin fails++; $display("FAIL both_mem: got %h expected cafef00d", mem[1]); end
        tests++;
        if (stall_cnt !== 4) begin fails++; $display("FAIL both_stall: got %0d expected 4", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        int gap;
        run_access(0, 1, 32'h0000_0020, 4'hf, 32'h1234_5678, 1, 1);
        exp_q.push_back(32'h1234_5678);
        run_access(1, 0, 32'h0000_0020, 4'hf, 32'h0, 0, 0);
        tests++;
        if (stall_cnt !== 4) begin fails++; $display("FAIL b2b_read_stall: got %0d expected 4", stall_cnt); end
        tests++;
        if (mem[15] !== 32'h1000_000F) begin fails++; $display("FAIL b2b_scramble: got %h expected 1000000f", mem[15]); end
        // Held request: the next access must start in the cycle right after DONE.
        bif.bus_read = 1'b1; bif.bus_address = 32'h0000_0020;
        @(negedge clk);
        gap = 0;
        while (!bif.bus_stall && gap < 5) begin @(negedge clk); gap++; end
        tests++;
        if (gap !== 0) begin fails++; $display("FAIL b2b_restart: got %0d idle cycles expected 0", gap); end
        while (bif.bus_stall && gap < 20) begin @(negedge clk); gap++; end
        @(posedge clk); #1; bif.bus_read = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int pulses = 0;
        @(posedge clk); #1;
        bif.bus_write = 1'b1; bif.bus_address = 32'h0000_0028; bif.bus_byteenable = 4'hf;
        bif.bus_wrdata = 32'h7777_7777;
        for (int c = 0; c < 10 && pulses < 2; c++) begin
            @(negedge clk);
            if (!bif.sram_we_n) pulses++;
        end
        #1;
        mem_en = 1'b0; rst = 1'b1; bif.bus_write = 1'b0;
        #1;
        tests++;
        if ({bif.sram_we_n, bif.sram_ce_n, bif.sram_data_oe, bif.bus_stall} !== 4'b1100) begin
            fails++; $display("FAIL rst_abort: got we/ce/doe/stall %b expected 1100",
                {bif.sram_we_n, bif.sram_ce_n, bif.sram_data_oe, bif.bus_stall});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); mem_en = 1'b1;
        tests++;
        if ({bif.bus_stall, bif.sram_ce_n, bif.bus_rddata} !== {1'b0, 1'b1, 32'h0}) begin
            fails++; $display("FAIL rst_idle: got stall %b ce_n %b rddata %h expected 0/1/0",
                bif.bus_stall, bif.sram_ce_n, bif.bus_rddata);
        end
        exp_q.push_back(32'h1122_AB44);
        run_access(1, 0, 32'h0000_0008, 4'hf, 32'h0, 0, 0);
        tests++;
        if (stall_cnt !== 4) begin fails++; $display("FAIL rst_recover_stall: got %0d expected 4", stall_cnt); end
    endtask

`ifdef SRAM_BRIDGE_BOUNDS_EN
    task automatic test_bounds();
        exp_q.push_back(32'h0);
        run_access(1, 0, 32'h0040_0000, 4'hf, 32'h0, 0, 0);
        tests++;
        if (ce_cnt !== 0) begin fails++; $display("FAIL bounds_ce: got %0d expected 0", ce_cnt); end
        tests++;
        if (err_cnt !== 1) begin fails++; $display("FAIL bounds_error: got %0d expected 1", err_cnt); end
        tests++;
        if (stall_cnt !== 1) begin fails++; $display("FAIL bounds_stall: got %0d expected 1", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_read_write_both();
        test_back_to_back();
        test_reset_mid_write();
`ifdef SRAM_BRIDGE_BOUNDS_EN
        test_bounds();
`endif
        tests++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
